shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter N, default 8: output word width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clr  input  1  synchronous abort; discards any partial or held word.
REQ-005 in_valid  input  1  in_bit is valid this cycle.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 in_ready  output  1  block accepts a bit this cycle.
REQ-008 dir  input  1  bit order: 0 = LSB first (right-shift assembly), 1 = MSB first (left-shift assembly).
REQ-009 out_valid  output  1  out_data holds a complete word.
REQ-010 out_data  output  N  assembled word.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 parity_err  output  1  parity mismatch flag for the word on out_data; qualified by out_valid.

Function
REQ-013 A bit SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-014 States SHALL be IDLE, COLLECT, PARITY (only when REQ-030 applies) and HOLD.
REQ-015 in_ready SHALL be 1 in IDLE, COLLECT and PARITY, and 0 in HOLD.
REQ-016 dir SHALL be sampled and latched on the first accepted bit of a word; dir changes later in the same word SHALL be ignored.
REQ-017 MSB-first: each accepted bit SHALL enter at bit 0, with the register shifting left by one.
REQ-018 LSB-first: each accepted bit SHALL enter at bit N-1, with the register shifting right by one.
REQ-019 A 0..N-1 bit counter SHALL increment per accepted data bit; IDLE -> COLLECT on the first accepted bit.
REQ-020 On acceptance of data bit N, state SHALL go to HOLD (or PARITY, REQ-030), and the counter SHALL wrap to 0.
REQ-021 out_valid SHALL rise in the cycle after the final bit is accepted (latency 1 clock).
REQ-022 In HOLD, out_valid and out_data SHALL stay stable until out_ready=1.
REQ-023 On the HOLD handshake the state SHALL go to IDLE, out_valid SHALL fall on the next edge, and in_ready SHALL return to 1 that same cycle; there is no same-cycle bypass.
REQ-024 in_valid with no gaps SHALL give one word per N accepted bits, plus the handshake cycle.
REQ-025 Gaps in in_valid SHALL pause assembly without loss of partial data.
REQ-026 clr=1 SHALL force IDLE, zero the counter and drop out_valid on the next edge, in any state.
REQ-027 clr SHALL take priority over a simultaneous in_valid or out_ready.

Reset
REQ-028 While rst_n=0: state IDLE, counter 0, shift register 0, out_valid 0, out_data 0, parity_err 0, latched dir 0.
REQ-029 Reset mid-word or in HOLD SHALL discard the word with no out_valid pulse; normal operation resumes on the first edge after rst_n rises.

Configuration
REQ-030 With macro SHIFT_DESER_PARITY_EN defined: after data bit N, the block SHALL enter PARITY, accept one even-parity bit, then go to HOLD.
REQ-031 In that mode, out_valid SHALL rise 1 clock after the parity bit is accepted.
REQ-032 In that mode, parity_err SHALL be 1 when the XOR of the N data bits and the parity bit is 1; it SHALL be held with out_data.
REQ-033 Without SHIFT_DESER_PARITY_EN: there is no PARITY state and parity_err SHALL be constant 0.

Verification
REQ-034 N=8, dir=1, bits 1,0,1,0,0,1,0,1 back-to-back, out_ready=1 -> out_data=8'hA5 with out_valid 1 cycle after the 8th bit, then IDLE.
REQ-035 N=8, dir=0, same bit sequence -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with 1,1,0,0,0,0,0,0 -> out_data=8'h03.
REQ-036 Word complete with out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0, offered bits not consumed; out_ready=1 -> IDLE next edge.
REQ-037 clr asserted after 4 bits together with in_valid=1 -> no word emitted; the next 8 bits form a fresh correct word.
REQ-038 rst_n pulsed low mid-word -> all outputs 0 immediately (asynchronous); the following word assembles correctly.
REQ-039 PARITY_EN, data 8'hA5 with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// ---------------------------------------------------------------------------
// shift_deserializer_if
// Bundles the serial-input and word-output handshakes of shift_deserializer.
//
// Parameter
//   N           output word width in bits
//
// Signals
//   in_valid    producer has a serial bit this cycle
//   in_bit      serial data bit
//   in_ready    deserializer can take a bit this cycle
//   dir         bit order: 0 = LSB first, 1 = MSB first
//   out_valid   out_data holds a complete word
//   out_data    assembled word
//   out_ready   consumer takes the word this cycle
//   parity_err  parity mismatch for the word on out_data
//
// Modports
//   master      the producer/consumer side (drives bits, takes words)
//   slave       the deserializer itself
// ---------------------------------------------------------------------------
interface shift_deserializer_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_bit;
    logic         in_ready;
    logic         dir;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_ready;
    logic         parity_err;

    modport master (
        output in_valid,
        output in_bit,
        output dir,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  parity_err
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  dir,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output parity_err
    );
endinterface

// File: rtl/shift_deserializer.sv
// ---------------------------------------------------------------------------
// shift_deserializer
// Assembles N serially delivered bits into one word and holds it until the
// consumer takes it. Bit order is chosen per word by dir, sampled on the
// first bit of the word.
//
// Optional feature (macro SHIFT_DESER_PARITY_EN):
//   after the N data bits one extra even-parity bit is accepted; parity_err
//   reports a mismatch alongside the word. Without the macro there is no
//   parity phase and parity_err is tied to 0.
//
// Parameter
//   N           output word width, 2..32
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous abort of any partial or held word
//   bus         shift_deserializer_if.slave (serial in / word out handshakes)
// ---------------------------------------------------------------------------
module shift_deserializer #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    shift_deserializer_if.slave  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SHIFT_DESER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2,
        HOLD    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd3
    } state_t;
`endif

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    sr_q;
    logic [N-1:0]    sr_shifted;
    logic            dir_q;
    logic            eff_dir;
    logic            accept;
    logic            accept_data;
    logic            last_data;
    logic            out_valid_q;
    logic [N-1:0]    out_data_q;

    assign bus.in_ready  = (state_q != HOLD);
    assign accept        = bus.in_valid && bus.in_ready;
    assign accept_data   = accept && ((state_q == IDLE) || (state_q == COLLECT));
    assign last_data     = accept_data && (cnt_q == CW'(N - 1));

    // The first bit of a word uses the live dir; every later bit uses the
    // copy latched on that first bit, so mid-word dir changes are ignored.
    assign eff_dir = (state_q == IDLE) ? bus.dir : dir_q;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Shift candidate for the current bit: MSB-first feeds bit 0 and shifts
    // left, LSB-first feeds bit N-1 and shifts right.
    always_comb begin
        sr_shifted = {bus.in_bit, sr_q[N-1:1]};
        if (eff_dir) begin
            sr_shifted = {sr_q[N-2:0], bus.in_bit};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. clr overrides every other transition, including a
    // simultaneous bit or handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (last_data) begin
`ifdef SHIFT_DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef SHIFT_DESER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

`ifdef SHIFT_DESER_PARITY_EN
    logic par_q;
    logic perr_q;

    assign bus.parity_err = perr_q;

    // Running XOR of the data bits, restarted on the first bit of a word;
    // the parity bit is folded in when it arrives and the result is held
    // alongside out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else if (clr) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (accept_data) begin
                par_q <= ((state_q == IDLE) ? 1'b0 : par_q) ^ bus.in_bit;
            end
            if (accept && (state_q == PARITY)) begin
                perr_q <= par_q ^ bus.in_bit;
            end
        end
    end
`else
    assign bus.parity_err = 1'b0;
`endif

    // Datapath: bit counter, shift register, latched bit order and the
    // output word. The output word is captured only when the word is
    // complete, so it never shows partial data while out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clr) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept_data) begin
                sr_q <= sr_shifted;
                if (state_q == IDLE) begin
                    dir_q <= bus.dir;
                end
                if (last_data) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
`ifdef SHIFT_DESER_PARITY_EN
            if (accept && (state_q == PARITY)) begin
                out_data_q  <= sr_q;
                out_valid_q <= 1'b1;
            end
`else
            if (last_data) begin
                out_data_q  <= sr_shifted;
                out_valid_q <= 1'b1;
            end
`endif
            if ((state_q == HOLD) && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// ---------------------------------------------------------------------------
// tb_shift_deserializer
// Directed bench for shift_deserializer with N = 8. Inputs change on the
// falling edge and outputs are sampled on the falling edge, half a cycle
// away from the rising edge where the design updates. Define
// SHIFT_DESER_PARITY_EN to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_shift_deserializer;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    logic clr;

    int check_cnt;
    int pass_cnt;

    shift_deserializer_if #(.N(N)) bus ();

    shift_deserializer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one 8-bit word; seq[7] is sent first. With gap set, an idle
    // cycle carrying a wrong bit follows every bit except the last. With
    // flip set, dir is inverted after the first bit. In the parity build the
    // even-parity bit (optionally inverted by inject) is appended. Returns
    // right after driving the final bit, before it is sampled.
    task automatic send_word(input logic [7:0] seq, input logic d,
                             input bit gap, input bit flip, input bit inject);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = seq[7-i];
            bus.dir      = (flip && (i > 0)) ? ~d : d;
            if (gap && (i < 7)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_bit   = ~seq[7-i];
            end
        end
`ifdef SHIFT_DESER_PARITY_EN
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = (^seq) ^ inject;
`else
        if (inject) begin
            bus.in_bit = seq[0];
        end
`endif
    endtask

    // Completes a word sent with out_ready=1 and checks the full timing:
    // no out_valid before the last bit is sampled, the word one cycle after,
    // then back to IDLE with in_ready high on the next cycle.
    task automatic test_word(input string name, input logic [7:0] seq,
                             input logic d, input bit gap, input bit flip,
                             input logic [7:0] expected);
        bus.out_ready = 1'b1;
        send_word(seq, d, gap, flip, 1'b0);
        check_cnt++;
        if (bus.out_valid !== 1'b0) begin
            $display("[TB] FAIL %s_early_valid: out_valid=%b required 0", name, bus.out_valid);
        end else pass_cnt++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_cnt++;
        if (bus.out_valid !== 1'b1) begin
            $display("[TB] FAIL %s_valid: out_valid=%b required 1", name, bus.out_valid);
        end else pass_cnt++;
        check_cnt++;
        if (bus.out_data !== expected) begin
            $display("[TB] FAIL %s_data: out_data=%h required %h", name, bus.out_data, expected);
        end else pass_cnt++;
        check_cnt++;
        if (bus.parity_err !== 1'b0) begin
            $display("[TB] FAIL %s_perr: parity_err=%b required 0", name, bus.parity_err);
        end else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            $display("[TB] FAIL %s_idle: out_valid=%b in_ready=%b required 0/1",
                     name, bus.out_valid, bus.in_ready);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.dir       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.out_data !== 8'h00) ||
            (bus.parity_err !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            $display("[TB] FAIL reset_state: valid=%b data=%h perr=%b in_ready=%b required 0/00/0/1",
                     bus.out_valid, bus.out_data, bus.parity_err, bus.in_ready);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            $display("[TB] FAIL reset_release: valid=%b in_ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end else pass_cnt++;
    endtask

    task automatic test_msb_first();
        test_word("msb_a5", 8'b1010_0101, 1'b1, 1'b0, 1'b0, 8'hA5);
        test_word("msb_c0", 8'b1100_0000, 1'b1, 1'b0, 1'b0, 8'hC0);
    endtask

    task automatic test_lsb_first();
        test_word("lsb_a5", 8'b1010_0101, 1'b0, 1'b0, 1'b0, 8'hA5);
        test_word("lsb_03", 8'b1100_0000, 1'b0, 1'b0, 1'b0, 8'h03);
    endtask

    task automatic test_dir_latch();
        test_word("latch_msb", 8'b1100_0000, 1'b1, 1'b0, 1'b1, 8'hC0);
        test_word("latch_lsb", 8'b1101_0000, 1'b0, 1'b0, 1'b1, 8'h0B);
    endtask

    task automatic test_gaps();
        test_word("gap_msb", 8'b0101_1010, 1'b1, 1'b1, 1'b0, 8'h5A);
        test_word("gap_lsb", 8'b1110_0001, 1'b0, 1'b1, 1'b0, 8'h87);
    endtask

    task automatic test_back_to_back();
        test_word("b2b_1", 8'b0011_1100, 1'b1, 1'b0, 1'b0, 8'h3C);
        test_word("b2b_2", 8'b1111_0000, 1'b1, 1'b0, 1'b0, 8'hF0);
        test_word("b2b_3", 8'b1000_0001, 1'b0, 1'b0, 1'b0, 8'h81);
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0;
        send_word(8'b1010_0101, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = c[0];
            check_cnt++;
            if ((bus.out_valid !== 1'b1) || (bus.out_data !== 8'hA5) || (bus.in_ready !== 1'b0)) begin
                $display("[TB] FAIL hold_cycle%0d: valid=%b data=%h in_ready=%b required 1/a5/0",
                         c, bus.out_valid, bus.out_data, bus.in_ready);
            end else pass_cnt++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_cnt++;
        if ((bus.out_valid !== 1'b1) || (bus.out_data !== 8'hA5)) begin
            $display("[TB] FAIL hold_before_ack: valid=%b data=%h required 1/a5",
                     bus.out_valid, bus.out_data);
        end else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
            $display("[TB] FAIL hold_release: valid=%b in_ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end else pass_cnt++;
        test_word("after_hold", 8'b0110_1001, 1'b1, 1'b0, 1'b0, 8'h69);
    endtask

    task automatic test_clr();
        logic [3:0] part;
        part = 4'b1011;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = part[3-i];
            bus.dir      = 1'b1;
        end
        @(negedge clk);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.out_data !== 8'h00)) begin
            $display("[TB] FAIL clr_abort: valid=%b data=%h required 0/00",
                     bus.out_valid, bus.out_data);
        end else pass_cnt++;
        test_word("after_clr", 8'b1001_0110, 1'b1, 1'b0, 1'b0, 8'h96);
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        send_word(8'b1010_0101, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_cnt++;
        if ((bus.out_valid !== 1'b1) || (bus.out_data !== 8'hA5)) begin
            $display("[TB] FAIL arst_setup: valid=%b data=%h required 1/a5",
                     bus.out_valid, bus.out_data);
        end else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.out_data !== 8'h00) ||
            (bus.in_ready !== 1'b1) || (bus.parity_err !== 1'b0)) begin
            $display("[TB] FAIL arst_hold: valid=%b data=%h in_ready=%b perr=%b required 0/00/1/0",
                     bus.out_valid, bus.out_data, bus.in_ready, bus.parity_err);
        end else pass_cnt++;
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_bit   = 1'b1;
            bus.dir      = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if ((bus.out_valid !== 1'b0) || (bus.out_data !== 8'h00)) begin
            $display("[TB] FAIL arst_midword: valid=%b data=%h required 0/00",
                     bus.out_valid, bus.out_data);
        end else pass_cnt++;
        #1 rst_n = 1'b1;
        test_word("after_arst", 8'b0100_1101, 1'b1, 1'b0, 1'b0, 8'h4D);
    endtask

`ifdef SHIFT_DESER_PARITY_EN
    task automatic test_parity();
        logic [1:0] inj;
        inj = 2'b10;
        for (int k = 0; k < 2; k++) begin
            bus.out_ready = 1'b1;
            send_word(8'hA5, 1'b1, 1'b0, 1'b0, inj[k]);
            check_cnt++;
            if (bus.out_valid !== 1'b0) begin
                $display("[TB] FAIL parity%0d_early: out_valid=%b required 0", k, bus.out_valid);
            end else pass_cnt++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            check_cnt++;
            if ((bus.out_valid !== 1'b1) || (bus.out_data !== 8'hA5)) begin
                $display("[TB] FAIL parity%0d_word: valid=%b data=%h required 1/a5",
                         k, bus.out_valid, bus.out_data);
            end else pass_cnt++;
            check_cnt++;
            if (bus.parity_err !== inj[k]) begin
                $display("[TB] FAIL parity%0d_err: parity_err=%b required %b",
                         k, bus.parity_err, inj[k]);
            end else pass_cnt++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        $display("[TB] shift_deserializer bench start");
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_dir_latch();
        test_gaps();
        test_back_to_back();
        test_hold();
        test_clr();
        test_async_reset();
`ifdef SHIFT_DESER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
